// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types for the memory-stage load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef struct packed {
        logic       is_store;
        logic [1:0] size;
        logic       is_unsigned;
    } lsu_op_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT_R = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } lsu_state_t;

    // Size 2'b11 is not a real access width, so it is treated as misaligned.
    function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] off);
        logic r_bad;
        case (op.size)
            SZ_B:    r_bad = 1'b0;
            SZ_H:    r_bad = off[0];
            SZ_W:    r_bad = (off != 2'b00);
            default: r_bad = 1'b1;
        endcase
        return r_bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Store lane replication / byte enables and load extract/extend.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  lsu_op_t           i_op,
    input  logic [1:0]        i_off,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [3:0]        o_be,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        case (i_op.size)
            SZ_B: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = i_op.is_unsigned ? {{(DATA_W-8){1'b0}}, w_byte}
                                           : {{(DATA_W-8){w_byte[7]}}, w_byte};
            end
            SZ_H: begin
                o_be    = 4'b0011 << i_off;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = i_op.is_unsigned ? {{(DATA_W-16){1'b0}}, w_half}
                                           : {{(DATA_W-16){w_half[15]}}, w_half};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
        // Loads always fetch the whole word; the lane is picked on return.
        if (!i_op.is_store) begin
            o_be = 4'b1111;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage
// Description : Memory-stage LSU: req/gnt/rvalid data port, load align/extend.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  lsu_op_t           ex_op,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              lsu_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              st_done,
    output logic              misalign,
    output logic [ADDR_W-1:0] misalign_addr
);

    lsu_state_t        r_state;
    lsu_state_t        w_state_nxt;
    lsu_op_t           r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_kill;
    logic              r_st_done;

    logic              w_accept;
    logic              w_misal;
    logic              w_in_req;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata_rep;
    logic [DATA_W-1:0] w_rdata_ext;

    assign w_accept = ex_valid && (r_state == IDLE);
    assign w_misal  = is_misaligned(ex_op, ex_addr[1:0]);
    assign w_in_req = (r_state == REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A grant always wins over a same-cycle flush; flush only withdraws an ungranted request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_misal ? ERR : REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    w_state_nxt = r_op.is_store ? IDLE : WAIT_R;
                end else if (flush) begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            ERR:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_op    <= ex_op;
            r_addr  <= ex_addr;
            r_wdata <= ex_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kill <= 1'b0;
        end else if (r_state == DONE) begin
            r_kill <= 1'b0;
        end else if (w_in_req && mem_gnt && flush && !r_op.is_store) begin
            r_kill <= 1'b1;
        end else if ((r_state == WAIT_R) && flush) begin
            r_kill <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st_done <= 1'b0;
            r_wb_data <= '0;
        end else begin
            r_st_done <= w_in_req && mem_gnt && r_op.is_store && !flush;
            if ((r_state == WAIT_R) && mem_rvalid) begin
                r_wb_data <= w_rdata_ext;
            end
        end
    end

    lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_op    (r_op),
        .i_off   (r_addr[1:0]),
        .i_wdata (r_wdata),
        .i_rdata (mem_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata_rep),
        .o_rdata (w_rdata_ext)
    );

    // Port fields are driven from captured state, so they stay frozen until grant.
    assign lsu_ready     = (r_state == IDLE);
    assign mem_req       = w_in_req;
    assign mem_we        = w_in_req && r_op.is_store;
    assign mem_addr      = w_in_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem_be        = w_in_req ? w_be : 4'b0000;
    assign mem_wdata     = w_in_req ? w_wdata_rep : '0;
    assign wb_valid      = (r_state == DONE) && !r_kill;
    assign wb_data       = r_wb_data;
    assign st_done       = r_st_done;
    assign misalign      = (r_state == ERR);
    assign misalign_addr = (r_state == ERR) ? r_addr : '0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_stage
// Description : Scoreboard bench for lsu_mem_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_stage;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    lsu_op_t     ex_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        lsu_ready;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        st_done;
    logic        misalign;
    logic [31:0] misalign_addr;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
    } exp_t;

    localparam logic [1:0] c_K_WB  = 2'd1;
    localparam logic [1:0] c_K_ST  = 2'd2;
    localparam logic [1:0] c_K_MIS = 2'd3;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    lsu_mem_stage #(
        .DATA_W (32),
        .ADDR_W (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_op         (ex_op),
        .ex_addr       (ex_addr),
        .ex_wdata      (ex_wdata),
        .lsu_ready     (lsu_ready),
        .flush         (flush),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .st_done       (st_done),
        .misalign      (misalign),
        .misalign_addr (misalign_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic lsu_op_t mk_op(input logic st, input logic [1:0] sz, input logic u);
        lsu_op_t o;
        o.is_store    = st;
        o.size        = sz;
        o.is_unsigned = u;
        return o;
    endfunction

    // Every result pulse must match the oldest expected entry.
    logic [1:0]  mon_kind;
    logic [31:0] mon_data;
    exp_t        mon_exp;
    always @(negedge clk) begin
        if (!rst && (wb_valid || st_done || misalign)) begin
            mon_kind = wb_valid ? c_K_WB : (st_done ? c_K_ST : c_K_MIS);
            mon_data = wb_valid ? wb_data : (misalign ? misalign_addr : 32'h0);
            if (sb_q.size() == 0) begin
                chk_eq("sb_unexpected_pulse", {30'b0, mon_kind}, 32'h0);
            end else begin
                mon_exp = sb_q.pop_front();
                chk_eq("sb_kind", {30'b0, mon_kind}, {30'b0, mon_exp.kind});
                chk_eq("sb_data", mon_data, mon_exp.data);
            end
        end
    end

    task automatic present(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] data);
        ex_valid = 1'b1;
        ex_op    = op;
        ex_addr  = addr;
        ex_wdata = data;
        chk_eq("accept_ready", {31'b0, lsu_ready}, 32'h1);
        tick();
        ex_valid = 1'b0;
        ex_op    = lsu_op_t'(4'($urandom));
        ex_addr  = $urandom;
        ex_wdata = $urandom;
    endtask

    task automatic do_load(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] rdata,
                           input int gnt_wait, input logic [31:0] exp_data);
        sb_q.push_back({c_K_WB, exp_data});
        present(op, addr, $urandom);
        for (int i = 0; i < gnt_wait; i++) begin
            chk_eq("ld_req_wait", {31'b0, mem_req}, 32'h1);
            tick();
        end
        mem_gnt = 1'b1;
        chk_eq("ld_req", {31'b0, mem_req}, 32'h1);
        chk_eq("ld_we", {31'b0, mem_we}, 32'h0);
        chk_eq("ld_be", {28'b0, mem_be}, 32'hF);
        chk_eq("ld_addr", mem_addr, {addr[31:2], 2'b00});
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        chk_eq("ld_wait_req", {31'b0, mem_req}, 32'h0);
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        chk_eq("ld_wb_valid", {31'b0, wb_valid}, 32'h1);
        tick();
        chk_eq("ld_wb_drop", {31'b0, wb_valid}, 32'h0);
        chk_eq("ld_ready_after", {31'b0, lsu_ready}, 32'h1);
    endtask

    task automatic do_store(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] data,
                            input int gnt_wait, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic fl_at_gnt);
        present(op, addr, data);
        for (int i = 0; i <= gnt_wait; i++) begin
            if (i == gnt_wait) begin
                mem_gnt = 1'b1;
                flush   = fl_at_gnt;
                if (!fl_at_gnt) sb_q.push_back({c_K_ST, 32'h0});
            end
            chk_eq("st_req", {31'b0, mem_req}, 32'h1);
            chk_eq("st_we", {31'b0, mem_we}, 32'h1);
            chk_eq("st_addr", mem_addr, exp_addr);
            chk_eq("st_be", {28'b0, mem_be}, {28'b0, exp_be});
            chk_eq("st_wdata", mem_wdata, exp_wdata);
            tick();
        end
        mem_gnt = 1'b0;
        flush   = 1'b0;
        chk_eq("st_done", {31'b0, st_done}, {31'b0, !fl_at_gnt});
        chk_eq("st_ready_after", {31'b0, lsu_ready}, 32'h1);
        tick();
        chk_eq("st_done_drop", {31'b0, st_done}, 32'h0);
    endtask

    task automatic do_misal(input lsu_op_t op, input logic [31:0] addr);
        sb_q.push_back({c_K_MIS, addr});
        present(op, addr, $urandom);
        chk_eq("mis_pulse", {31'b0, misalign}, 32'h1);
        chk_eq("mis_addr", misalign_addr, addr);
        chk_eq("mis_no_req", {31'b0, mem_req}, 32'h0);
        chk_eq("mis_not_ready", {31'b0, lsu_ready}, 32'h0);
        tick();
        chk_eq("mis_drop", {31'b0, misalign}, 32'h0);
        chk_eq("mis_ready_after", {31'b0, lsu_ready}, 32'h1);
        chk_eq("mis_no_req_after", {31'b0, mem_req}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        ex_valid   = 1'b0;
        ex_op      = '0;
        ex_addr    = '0;
        ex_wdata   = '0;
        flush      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        tick();
        tick();
        chk_eq("rst_ready", {31'b0, lsu_ready}, 32'h1);
        chk_eq("rst_req", {31'b0, mem_req}, 32'h0);
        chk_eq("rst_we", {31'b0, mem_we}, 32'h0);
        chk_eq("rst_addr", mem_addr, 32'h0);
        chk_eq("rst_be", {28'b0, mem_be}, 32'h0);
        chk_eq("rst_wdata", mem_wdata, 32'h0);
        chk_eq("rst_wb", {31'b0, wb_valid}, 32'h0);
        chk_eq("rst_wb_data", wb_data, 32'h0);
        chk_eq("rst_st_done", {31'b0, st_done}, 32'h0);
        chk_eq("rst_misalign", {31'b0, misalign}, 32'h0);
        chk_eq("rst_mis_addr", misalign_addr, 32'h0);
        rst = 1'b0;
        tick();

        do_load(mk_op(1'b0, SZ_B, 1'b1), 32'h0000_1003, 32'hAB00_0000, 0, 32'h0000_00AB);
        do_load(mk_op(1'b0, SZ_B, 1'b0), 32'h0000_1003, 32'hAB00_0000, 0, 32'hFFFF_FFAB);
        do_load(mk_op(1'b0, SZ_B, 1'b1), 32'h0000_1001, 32'h1111_C322, 1, 32'h0000_00C3);
        do_load(mk_op(1'b0, SZ_W, 1'b0), 32'h0000_8004, 32'h1234_5678, 0, 32'h1234_5678);

        do_store(mk_op(1'b1, SZ_H, 1'b0), 32'h0000_2002, 32'h0000_BEEF, 2,
                 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 1'b0);
        do_store(mk_op(1'b1, SZ_W, 1'b0), 32'h0000_8000, 32'hDEAD_BEEF, 0,
                 32'h0000_8000, 4'b1111, 32'hDEAD_BEEF, 1'b0);

        do_misal(mk_op(1'b0, SZ_W, 1'b0), 32'h0000_3001);
        do_misal(mk_op(1'b0, SZ_H, 1'b0), 32'h0000_9001);
        do_misal(mk_op(1'b1, 2'b11, 1'b0), 32'h0000_9000);

        // Load killed by a flush while waiting for read data.
        present(mk_op(1'b0, SZ_H, 1'b0), 32'h0000_4000, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        flush   = 1'b1;
        tick();
        flush = 1'b0;
        chk_eq("kill_no_req", {31'b0, mem_req}, 32'h0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_8001;
        tick();
        mem_rvalid = 1'b0;
        chk_eq("kill_no_wb", {31'b0, wb_valid}, 32'h0);
        tick();
        chk_eq("kill_ready", {31'b0, lsu_ready}, 32'h1);
        do_load(mk_op(1'b0, SZ_H, 1'b0), 32'h0000_4002, 32'hF00D_1234, 1, 32'hFFFF_F00D);

        // Ungranted request withdrawn by flush.
        present(mk_op(1'b1, SZ_W, 1'b0), 32'h0000_5000, 32'h0102_0304);
        chk_eq("wd_req", {31'b0, mem_req}, 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_eq("wd_req_drop", {31'b0, mem_req}, 32'h0);
        chk_eq("wd_ready", {31'b0, lsu_ready}, 32'h1);
        tick();
        chk_eq("wd_no_done", {31'b0, st_done}, 32'h0);

        // Flush coincident with grant on a store.
        do_store(mk_op(1'b1, SZ_B, 1'b0), 32'h0000_6001, 32'h1234_565A, 0,
                 32'h0000_6000, 4'b0010, 32'h5A5A_5A5A, 1'b1);

        // Reset while waiting for read data, then a stray rvalid.
        present(mk_op(1'b0, SZ_W, 1'b0), 32'h0000_7000, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst     = 1'b1;
        tick();
        rst        = 1'b0;
        chk_eq("rw_ready", {31'b0, lsu_ready}, 32'h1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        chk_eq("rw_no_wb", {31'b0, wb_valid}, 32'h0);
        chk_eq("rw_wb_data", wb_data, 32'h0);
        chk_eq("rw_req", {31'b0, mem_req}, 32'h0);
        chk_eq("rw_ready_after", {31'b0, lsu_ready}, 32'h1);
        tick();
        chk_eq("rw_no_wb_late", {31'b0, wb_valid}, 32'h0);

        do_load(mk_op(1'b0, SZ_H, 1'b1), 32'h0000_4002, 32'h8001_1234, 0, 32'h0000_8001);

        tick();
        chk_eq("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit in the memory stage, directly downstream of the execute ALU.
- Consumes the effective address the ALU computes for LB/LH/LW/LBU/LHU/SB/SH/SW (ALU add op) plus the store operand.
- Runs a req/gnt/rvalid transaction on the data-memory port, aligns and extends load data, and returns it to writeback.
- Stalls the pipeline through lsu_ready while a transaction is outstanding.

Parameters:
- DATA_W, 32, data word width; must equal the shared `data_size`. Only 32 is supported.
- ADDR_W, 32, byte-address width.

Ports:
- clk, in, 1, core clock.
- rst, in, 1, synchronous active-high reset.
- ex_valid, in, 1, a memory op is presented by execute.
- ex_op, in, lsu_op_t (4), {is_store, size[1:0], is_unsigned}. Size encoding: 00 byte, 01 half, 10 word, 11 illegal.
- ex_addr, in, ADDR_W, effective address (ALU Out).
- ex_wdata, in, DATA_W, store operand (rs2).
- lsu_ready, out, 1, LSU can accept; high only in IDLE.
- flush, in, 1, kill the in-flight op (branch/exception).
- mem_req, out, 1, memory request.
- mem_we, out, 1, write enable.
- mem_addr, out, ADDR_W, word-aligned address; bits [1:0] always 0.
- mem_be, out, 4, byte enables.
- mem_wdata, out, DATA_W, lane-replicated store data.
- mem_gnt, in, 1, request accepted.
- mem_rvalid, in, 1, read data valid.
- mem_rdata, in, DATA_W, read data.
- wb_valid, out, 1, one-cycle pulse: load result valid.
- wb_data, out, DATA_W, extended load result.
- st_done, out, 1, one-cycle pulse: store granted.
- misalign, out, 1, one-cycle pulse: misaligned or illegal op.
- misalign_addr, out, ADDR_W, offending address.

Behaviour:
- Reset: state IDLE. mem_req, mem_we, wb_valid, st_done and misalign are 0. mem_be, mem_addr, mem_wdata, wb_data and misalign_addr are 0. The kill flag is 0.
- A reset in any state returns the LSU to IDLE within one edge. A mem_rvalid arriving after reset is ignored.
- Accept: ex_valid && lsu_ready at a rising edge. op, addr and wdata are captured into registers. ex_* is don't-care at all other times.
- Misaligned condition, checked at accept:
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - size=11.
  - Action: go to ERR and issue no memory request.
- States:
  - IDLE: lsu_ready=1.
    - Accept, aligned → REQ.
    - Accept, misaligned → ERR.
  - ERR: misalign=1 and misalign_addr=captured address for exactly this cycle → IDLE.
  - REQ: mem_req=1. mem_we, mem_addr, mem_be and mem_wdata are held stable until grant.
    - gnt && store → IDLE, with st_done pulsed in the next cycle.
    - gnt && load → WAIT_R.
    - flush && !gnt → IDLE. The request is withdrawn and nothing is pulsed.
    - flush && gnt in the same cycle: the grant wins and the transaction proceeds. A load proceeds with kill set; a store completes with st_done suppressed.
  - WAIT_R: mem_req=0.
    - flush sets kill.
    - mem_rvalid → DONE; wb_data is registered from mem_rdata.
  - DONE: wb_valid = !kill for one cycle; kill is cleared → IDLE.
- The memory guarantees rvalid comes at least one cycle after gnt. rvalid seen in IDLE, REQ or ERR is ignored.
- Store lanes, with off = addr[1:0]:
  - byte: be = 4'b0001 << off, wdata = {4{d[7:0]}}.
  - half: be = 4'b0011 << off, wdata = {2{d[15:0]}}.
  - word: be = 4'b1111, wdata = d.
  - Loads drive be=4'b1111 and mem_we=0.
- Load extract: select byte rdata[8*off +: 8] or half rdata[16*off[1] +: 16]. Sign-extend unless is_unsigned; word loads pass through.
- Minimum latency:
  - load: accept → wb_valid is 3 cycles (gnt in the first REQ cycle, rvalid in the next).
  - store: accept → st_done is 2 cycles.

Decomposition:
- Package lsu_pkg holds:
  - lsu_op_t (packed struct);
  - size constants SZ_B, SZ_H, SZ_W;
  - state enum lsu_state_t {IDLE, REQ, WAIT_R, DONE, ERR}.
- Sub-module lsu_align (combinational): store-lane replication/byte enables plus load extract/extend. It is shared by both paths and unit-testable on its own.

Test Plan:
- LBU at addr 0x1003, rdata=0xAB000000, gnt immediate, rvalid next → wb_data=0x000000AB, wb_valid 3 cycles after accept. The same with LB → 0xFFFFFFAB.
- SH at 0x2002 with data 0x0000BEEF, gnt after 2 wait cycles → mem_addr=0x2000, mem_be=4'b1100, mem_wdata=0xBEEFBEEF held stable throughout REQ; one st_done pulse.
- LW at 0x3001 → misalign=1 and misalign_addr=0x3001 for one cycle, mem_req never asserted, lsu_ready back high the next cycle.
- LH at 0x4000, flush asserted in WAIT_R, rvalid 0x00008001 two cycles later → no wb_valid, LSU returns to IDLE, and the next op is accepted normally.
- Flush in REQ with gnt low → mem_req drops, no pulses. Flush coincident with gnt for a store → transaction completes, st_done suppressed.
- rst asserted in WAIT_R followed by a stray rvalid → all outputs 0, state IDLE, no wb_valid.
